// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between IF and mem_ctrl.
// Define ICACHE_STAT_EN to add the hit_cnt_o / miss_cnt_o counters.
module icache #(
    parameter int INDEX_W = 6,
    parameter int ADDR_W  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        fe_i,
    input  logic [31:0] fpc_i,
    output logic        inst_ok_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_done_i,
    input  logic [31:0] mem_inst_i
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MISS = 1'b1;
    localparam logic [LINES-1:0] ONE = 1;

    logic [0:0]         state;
    logic [31:0]        data_arr [LINES];
    logic [TAG_W-1:0]   tag_arr [LINES];
    logic [LINES-1:0]   valid;
    logic [31:0]        pc_al;
    logic [INDEX_W-1:0] idx, fill_idx;
    logic [TAG_W-1:0]   tag, fill_tag;
    logic               hit, fill_io, fill_set, do_fill, do_hit, do_miss;
    logic               unused_ok;

    assign pc_al     = {fpc_i[31:2], 2'b00};
    assign idx       = fpc_i[INDEX_W+1:2];
    assign tag       = fpc_i[ADDR_W-1:INDEX_W+2];
    assign hit       = valid[idx] && tag_arr[idx] == tag && fpc_i[ADDR_W-1 -: 2] != 2'b11;
    assign unused_ok = ^fpc_i[1:0];

    // mem_addr_o doubles as the latched miss address for the refill
    assign fill_idx = mem_addr_o[INDEX_W+1:2];
    assign fill_tag = mem_addr_o[ADDR_W-1:INDEX_W+2];
    assign fill_io  = mem_addr_o[ADDR_W-1 -: 2] == 2'b11;

    // a flush in the lookup cycle turns a would-be hit into a miss
    assign do_hit   = rdy && state == IDLE && fe_i && hit && !flush;
    assign do_miss  = rdy && state == IDLE && fe_i && !(hit && !flush);
    assign do_fill  = rdy && state == MISS && mem_done_i;
    assign fill_set = do_fill && !fill_io;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            valid      <= '0;
            inst_ok_o  <= 1'b0;
            inst_o     <= '0;
            inst_pc_o  <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else if (rdy) begin
            state      <= do_miss ? MISS : do_fill ? IDLE : state;
            valid      <= (flush ? '0 : valid) | (fill_set ? ONE << fill_idx : '0);
            inst_ok_o  <= do_hit || do_fill;
            inst_o     <= do_fill ? mem_inst_i : do_hit ? data_arr[idx] : inst_o;
            inst_pc_o  <= do_fill ? mem_addr_o : do_hit ? pc_al : inst_pc_o;
            mem_req_o  <= do_miss ? 1'b1 : do_fill ? 1'b0 : mem_req_o;
            mem_addr_o <= do_miss ? pc_al : mem_addr_o;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_set) begin
            data_arr[fill_idx] <= mem_inst_i;
            tag_arr[fill_idx]  <= fill_tag;
        end
    end

`ifdef ICACHE_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            hit_cnt_o  <= do_hit ? hit_cnt_o + 32'd1 : hit_cnt_o;
            miss_cnt_o <= do_miss ? miss_cnt_o + 32'd1 : miss_cnt_o;
        end
    end
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized scoreboard bench for icache with a line-ownership reference model
// and a memory responder that serves refills with random latency.
module tb_icache;
    localparam int IW = 6;
    logic        clk = 0, rst = 1, rdy = 1, flush = 0, fe_i = 0, mem_done_i = 0;
    logic [31:0] fpc_i = 0, mem_inst_i = 0;
    logic        inst_ok_o, mem_req_o;
    logic [31:0] inst_o, inst_pc_o, mem_addr_o;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_o, miss_cnt_o;
`endif
    int          total = 0, bad = 0, n_hit = 0, n_miss = 0, fix_dly = -1;
    bit          rand_wait = 0;
    logic [31:0] wait_pc = 0;
    logic [63:0] exp_q[$];
    logic [31:0] miss_q[$];
    logic [31:0] line_addr [1<<IW];
    bit          line_ok [1<<IW];

    always #5 clk = ~clk;

    icache dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .fe_i(fe_i), .fpc_i(fpc_i),
        .inst_ok_o(inst_ok_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_done_i(mem_done_i), .mem_inst_i(mem_inst_i)
`ifdef ICACHE_STAT_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    // memory contents depend only on the meaningful word address [17:2]
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [15:0] w;
        w = a[17:2];
        if (w == 16'h0040) return 32'h0010_0093;
        if (w == 16'h0080) return 32'hDEAD_BEEF;
        return {w, ~w} ^ 32'h5A3C_0F96;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        foreach (line_ok[i]) line_ok[i] = 0;
    endtask

    task automatic do_flush();
        rdy = 1; fe_i = 0; flush = 1;
        model_clear();
        @(posedge clk); #1;
        flush = 0;
    endtask

    // One fetch; a miss keeps driving filler inputs until the refill result appears.
    task automatic fetch(input logic [31:0] pc, input bit fl);
        logic [31:0] a;
        logic [IW-1:0] ix;
        bit hit, fw;
        int k;
        a = {pc[31:2], 2'b00};
        ix = a[IW+1:2];
        if (fl) model_clear();
        hit = a[17:16] != 2'b11 && line_ok[ix] && line_addr[ix][17:2] == a[17:2];
        rdy = 1; fe_i = 1; fpc_i = pc; flush = fl;
        exp_q.push_back({a, mem_word(a)});
        if (hit) n_hit++;
        else begin
            n_miss++;
            miss_q.push_back(a);
        end
        @(posedge clk); #1;
        flush = 0;
        if (!hit) begin
            k = 0;
            while (!inst_ok_o && k < 100) begin
                fw = rand_wait && $urandom_range(0, 7) == 0;
                fe_i = rand_wait ? 1'($urandom) : 1'b1;
                fpc_i = rand_wait ? $urandom : wait_pc;
                flush = fw;
                if (fw) model_clear();
                @(posedge clk); #1;
                k++;
            end
            flush = 0;
            total++;
            if (k >= 100) begin
                bad++;
                $display("FAIL refill_timeout: pc %h got no result within %0d cycles", a, k);
            end
            if (a[17:16] != 2'b11) begin
                line_ok[ix] = 1;
                line_addr[ix] = a;
            end
        end
        fe_i = 0;
    endtask

    // result monitor: a fresh result is inst_ok_o after an edge where rdy was high
    initial forever begin
        bit r;
        logic [63:0] e;
        @(negedge clk); r = rdy && rst;
        @(posedge clk); #1;
        if (r && rst && inst_ok_o) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_result: got pc %h inst %h, want nothing pending", inst_pc_o, inst_o);
            end else begin
                e = exp_q.pop_front();
                chk("result_pc", inst_pc_o, e[63:32]);
                chk("result_inst", inst_o, e[31:0]);
            end
        end
    end

    // memory responder: checks request address against the pending miss and answers after a delay
    initial forever begin
        bit busy;
        int cnt;
        logic [31:0] ea;
        @(posedge clk); #1;
        mem_done_i = 0;
        if (!rst) busy = 0;
        else if (mem_req_o) begin
            if (!busy) begin
                busy = 1;
                if (miss_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_req: got addr %h, want no request", mem_addr_o);
                    ea = 32'hFFFF_FFFC;
                end else ea = miss_q.pop_front();
                cnt = fix_dly >= 0 ? fix_dly : $urandom_range(0, 5);
            end
            chk("mem_addr", mem_addr_o, ea);
            if (cnt == 0) begin
                mem_done_i = 1;
                mem_inst_i = mem_word(ea);
                busy = 0;
            end else cnt--;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pc;
        model_clear();
        #2 rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ok", 32'(inst_ok_o), 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_pc", inst_pc_o, 0);
        chk("rst_req", 32'(mem_req_o), 0);
        chk("rst_addr", mem_addr_o, 0);
        rst = 1;
        fetch(32'h100, 0);
        repeat (3) fetch(32'h100, 0);
        fetch(32'h200, 0);
        fetch(32'h100, 0);
        fetch(32'h200, 0);
        fix_dly = 5; wait_pc = 32'h300;
        fetch(32'h102, 0);
        fix_dly = -1;
        fetch(32'h300, 0);
        fetch(32'h104, 0);
        fetch(32'h100, 0);
        fetch(32'h104, 0);
        do_flush();
        fetch(32'h100, 0);
        fetch(32'h104, 0);
        fetch(32'h100, 0);
        rdy = 0; fe_i = 1; fpc_i = 32'h104;
        repeat (3) begin
            @(posedge clk); #1;
            chk("freeze_ok", 32'(inst_ok_o), 1);
            chk("freeze_pc", inst_pc_o, 32'h100);
        end
        rdy = 1; fe_i = 0;
        fetch(32'h3_0100, 0);
        fetch(32'h3_0100, 0);
        fetch(32'h4_0100, 0);
        fetch(32'h208, 1);
        fetch(32'h208, 0);
        fix_dly = 1000;
        fe_i = 1; fpc_i = 32'h500;
        miss_q.push_back(32'h500);
        @(posedge clk); #1;
        fe_i = 0;
        chk("miss_req", 32'(mem_req_o), 1);
        @(posedge clk); #3;
        rst = 0; #1;
        chk("async_rst_req", 32'(mem_req_o), 0);
        chk("async_rst_addr", mem_addr_o, 0);
        miss_q.delete();
        model_clear();
        n_hit = 0; n_miss = 0; fix_dly = -1;
        @(posedge clk); #1;
        rst = 1;
        fetch(32'h100, 0);
        fetch(32'h104, 0);
        fetch(32'h100, 0);
        rand_wait = 1;
        for (int i = 0; i < 400; i++) begin
            pc = {$urandom_range(0, 7) == 0 ? 14'($urandom) : 14'd0, 2'($urandom),
                  8'($urandom_range(0, 2)), 6'($urandom_range(0, 7)), 2'($urandom)};
            fetch(pc, $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end
        end
        repeat (5) @(posedge clk);
        #1;
        chk("results_left", exp_q.size(), 0);
        chk("misses_left", miss_q.size(), 0);
`ifdef ICACHE_STAT_EN
        chk("hit_cnt", hit_cnt_o, n_hit);
        chk("miss_cnt", miss_cnt_o, n_miss);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
